// File: rtl/hazard_stall_if.sv
// Decode-stage hazard bundle: pipeline hazard fields in, stall/flush controls
// and debug statistics out.
interface hazard_stall_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_branch_taken;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_mem_read;
  logic [4:0]       mem_rt;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output id_branch, id_branch_taken, id_jump,
    output ex_mem_read, ex_rt,
    output mem_mem_read, mem_rt,
    input  pc_stall, if_id_stall, id_ex_bubble,
    input  if_id_flush, stall_active,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  id_branch, id_branch_taken, id_jump,
    input  ex_mem_read, ex_rt,
    input  mem_mem_read, mem_rt,
    output pc_stall, if_id_stall, id_ex_bubble,
    output if_id_flush, stall_active,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-on-load stall controller with IF/ID flush on taken
// control transfers and free-running stall/flush statistics.
module hazard_stall_unit #(
  parameter int LOAD_USE_STALLS    = 1,
  parameter int BRANCH_LOAD_STALLS = 2,
  parameter int CNT_W              = 32
) (
  input logic           clk,
  input logic           rst_n,
  hazard_stall_if.slave bus
);

  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 3 ||
      BRANCH_LOAD_STALLS < 1 || BRANCH_LOAD_STALLS > 3) begin : g_param_err
    $error("hazard_stall_unit: stall counts must be 1..3");
  end

  localparam logic [1:0] LU_N = 2'(LOAD_USE_STALLS);
  localparam logic [1:0] BL_N = 2'(BRANCH_LOAD_STALLS);

  typedef enum logic {
    S_IDLE,
    S_STALL
  } state_t;

  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic       w_match_ex;
  logic       w_match_mem;
  logic [1:0] w_need;
  logic       w_stall;
  logic       w_flush;

  assign w_match_ex = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
    ((bus.ex_rt == bus.id_rs) ||
     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  assign w_match_mem = bus.mem_mem_read && (bus.mem_rt != 5'd0) &&
    bus.id_branch &&
    ((bus.mem_rt == bus.id_rs) ||
     (bus.id_uses_rt && (bus.mem_rt == bus.id_rt)));

  always_comb begin
    w_need = 2'd0;
    unique case (1'b1)
      (w_match_ex && bus.id_branch):  w_need = BL_N;
      (w_match_ex && !bus.id_branch): w_need = LU_N;
      (!w_match_ex && w_match_mem):   w_need = 2'd1;
      default:                        w_need = 2'd0;
    endcase
  end

  // Controls are forced low while reset is held, even with live hazards.
  assign w_stall = rst_n &&
    ((r_state == S_STALL) || (w_need != 2'd0));
  assign w_flush = rst_n && !w_stall &&
    (bus.id_branch_taken || bus.id_jump);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 2'd0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_need > 2'd1) begin
            r_state <= S_STALL;
            r_cnt   <= w_need - 2'd1;
          end
        end
        S_STALL: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_IDLE;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
      if (w_stall) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush) r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign bus.pc_stall     = w_stall;
  assign bus.if_id_stall  = w_stall;
  assign bus.id_ex_bubble = w_stall;
  assign bus.if_id_flush  = w_flush;
  assign bus.stall_active = (r_state == S_STALL);
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: default instance plus a
// BRANCH_LOAD_STALLS=3 / CNT_W=4 instance for reset-mid-stall and wrap.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst_n1;
  logic rst_n2;

  always #5 clk = ~clk;

  hazard_stall_if #(.CNT_W(32)) ifc1 ();
  hazard_stall_if #(.CNT_W(4))  ifc2 ();

  hazard_stall_unit u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (ifc1.slave)
  );

  hazard_stall_unit #(
    .BRANCH_LOAD_STALLS (3),
    .CNT_W              (4)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n2),
    .bus   (ifc2.slave)
  );

  typedef struct {
    int          sel;
    string       nm;
    logic        st;
    logic        fl;
    logic        ac;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  event ev_chk;

  task automatic chk1(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pop every pending expectation and compare against the DUT.
  initial begin
    exp_t e;
    logic [31:0] a_pc, a_ifid, a_bub, a_fl, a_ac, a_sc, a_fe;
    forever begin
      @(negedge clk or ev_chk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 1) begin
          a_pc   = {31'd0, ifc1.pc_stall};
          a_ifid = {31'd0, ifc1.if_id_stall};
          a_bub  = {31'd0, ifc1.id_ex_bubble};
          a_fl   = {31'd0, ifc1.if_id_flush};
          a_ac   = {31'd0, ifc1.stall_active};
          a_sc   = ifc1.stall_cycles;
          a_fe   = ifc1.flush_events;
        end else begin
          a_pc   = {31'd0, ifc2.pc_stall};
          a_ifid = {31'd0, ifc2.if_id_stall};
          a_bub  = {31'd0, ifc2.id_ex_bubble};
          a_fl   = {31'd0, ifc2.if_id_flush};
          a_ac   = {31'd0, ifc2.stall_active};
          a_sc   = {28'd0, ifc2.stall_cycles};
          a_fe   = {28'd0, ifc2.flush_events};
        end
        chk1({e.nm, ".pc_stall"},     a_pc,   {31'd0, e.st});
        chk1({e.nm, ".if_id_stall"},  a_ifid, {31'd0, e.st});
        chk1({e.nm, ".id_ex_bubble"}, a_bub,  {31'd0, e.st});
        chk1({e.nm, ".if_id_flush"},  a_fl,   {31'd0, e.fl});
        chk1({e.nm, ".stall_active"}, a_ac,   {31'd0, e.ac});
        chk1({e.nm, ".stall_cycles"}, a_sc,   e.sc);
        chk1({e.nm, ".flush_events"}, a_fe,   e.fe);
      end
    end
  end

  task automatic clr();
    ifc1.id_rs = 5'd0;  ifc1.id_rt = 5'd0;  ifc1.id_uses_rt = 1'b0;
    ifc1.id_branch = 1'b0; ifc1.id_branch_taken = 1'b0;
    ifc1.id_jump = 1'b0;
    ifc1.ex_mem_read = 1'b0;  ifc1.ex_rt = 5'd0;
    ifc1.mem_mem_read = 1'b0; ifc1.mem_rt = 5'd0;
    ifc2.id_rs = 5'd0;  ifc2.id_rt = 5'd0;  ifc2.id_uses_rt = 1'b0;
    ifc2.id_branch = 1'b0; ifc2.id_branch_taken = 1'b0;
    ifc2.id_jump = 1'b0;
    ifc2.ex_mem_read = 1'b0;  ifc2.ex_rt = 5'd0;
    ifc2.mem_mem_read = 1'b0; ifc2.mem_rt = 5'd0;
  endtask

  function automatic exp_t mk(input int sel, input string nm,
      input logic st, input logic fl, input logic ac,
      input logic [31:0] sc, input logic [31:0] fe);
    exp_t e;
    e.sel = sel; e.nm = nm; e.st = st; e.fl = fl; e.ac = ac;
    e.sc = sc; e.fe = fe;
    return e;
  endfunction

  // Inputs are already applied; record the expectation, then advance a cycle.
  task automatic cyc(input int sel, input string nm,
      input logic st, input logic fl, input logic ac,
      input logic [31:0] sc, input logic [31:0] fe);
    q.push_back(mk(sel, nm, st, fl, ac, sc, fe));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    @(posedge clk);
    #1;
    // Live hazard and jump during reset must not reach the outputs.
    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd8; ifc1.id_rs = 5'd8;
    ifc1.id_jump = 1'b1;
    cyc(1, "reset", 0, 0, 0, 0, 0);
    clr();
    rst_n1 = 1'b1;
    rst_n2 = 1'b1;
    cyc(1, "idle", 0, 0, 0, 0, 0);

    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd8; ifc1.id_rs = 5'd8;
    cyc(1, "lu_stall", 1, 0, 0, 0, 0);
    clr();
    cyc(1, "lu_done", 0, 0, 0, 1, 0);

    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd9;
    ifc1.id_rt = 5'd9; ifc1.id_uses_rt = 1'b1; ifc1.id_branch = 1'b1;
    cyc(1, "bl_c1", 1, 0, 0, 1, 0);
    clr();
    ifc1.id_jump = 1'b1; ifc1.id_branch_taken = 1'b1; ifc1.id_rs = 5'd3;
    cyc(1, "bl_c2_toggled", 1, 0, 1, 2, 0);
    clr();
    cyc(1, "bl_done", 0, 0, 0, 3, 0);

    ifc1.mem_mem_read = 1'b1; ifc1.mem_rt = 5'd5;
    ifc1.id_rs = 5'd5; ifc1.id_branch = 1'b1;
    cyc(1, "mem_br", 1, 0, 0, 3, 0);
    ifc1.id_branch = 1'b0;
    cyc(1, "mem_nobr", 0, 0, 0, 4, 0);
    clr();
    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd0; ifc1.id_rs = 5'd0;
    cyc(1, "reg0", 0, 0, 0, 4, 0);
    clr();

    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd9; ifc1.id_rs = 5'd9;
    ifc1.id_branch = 1'b1; ifc1.id_branch_taken = 1'b1;
    cyc(1, "tk_c1", 1, 0, 0, 4, 0);
    cyc(1, "tk_c2", 1, 0, 1, 5, 0);
    ifc1.ex_mem_read = 1'b0;
    cyc(1, "tk_flush", 0, 1, 0, 6, 0);
    clr();
    cyc(1, "tk_after", 0, 0, 0, 6, 1);

    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd3; ifc1.id_rs = 5'd3;
    cyc(1, "b2b_a", 1, 0, 0, 6, 1);
    ifc1.ex_rt = 5'd4; ifc1.id_rs = 5'd1;
    ifc1.id_rt = 5'd4; ifc1.id_uses_rt = 1'b1;
    cyc(1, "b2b_b", 1, 0, 0, 7, 1);
    clr();
    cyc(1, "b2b_done", 0, 0, 0, 8, 1);
    ifc1.ex_mem_read = 1'b1; ifc1.ex_rt = 5'd6; ifc1.id_rt = 5'd6;
    cyc(1, "rt_unused", 0, 0, 0, 8, 1);
    clr();

    ifc2.ex_mem_read = 1'b1; ifc2.ex_rt = 5'd9; ifc2.id_rs = 5'd9;
    ifc2.id_branch = 1'b1;
    cyc(2, "bl3_c1", 1, 0, 0, 0, 0);
    q.push_back(mk(2, "bl3_c2", 1, 0, 1, 1, 0));
    @(negedge clk);
    #2;
    rst_n2 = 1'b0;
    q.push_back(mk(2, "rst_mid", 0, 0, 0, 0, 0));
    -> ev_chk;
    @(posedge clk);
    #1;
    cyc(2, "rst_hold", 0, 0, 0, 0, 0);
    rst_n2 = 1'b1;
    clr();
    cyc(2, "post_rst", 0, 0, 0, 0, 0);

    ifc2.ex_mem_read = 1'b1; ifc2.ex_rt = 5'd9; ifc2.id_rs = 5'd9;
    ifc2.id_branch = 1'b1;
    cyc(2, "bl3_s1", 1, 0, 0, 0, 0);
    cyc(2, "bl3_s2", 1, 0, 1, 1, 0);
    cyc(2, "bl3_s3", 1, 0, 1, 2, 0);
    clr();
    cyc(2, "bl3_done", 0, 0, 0, 3, 0);

    ifc2.id_jump = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc(2, $sformatf("wrap%0d", i), 0, 1, 0, 3, 32'(i % 16));
    end
    clr();
    cyc(2, "wrap_end", 0, 0, 0, 3, 1);

    repeat (2) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
